// File: rtl/msg_tx_arbiter.sv
// Round-robin arbiter that shares one message-loader/UART TX path among NUM_REQ requesters.
// Grants one requester, pulses start_msg, holds the grant until completion, then inserts an idle gap.
module msg_tx_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned IDX_W          = 2,
  parameter int unsigned GAP_CYCLES     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               fifo_empty,
  input  logic               tx_busy,
  input  logic               msg_done,
  output logic               start_msg,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               busy,
  output logic               timeout_err
);

  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int unsigned TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_GAP
  } state_t;

  state_t             state, state_n;
  logic [IDX_W-1:0]   ptr, ptr_n;
  logic [GAP_W-1:0]   gap_cnt, gap_n;
  logic [TO_W-1:0]    to_cnt, to_n;
  logic [NUM_REQ-1:0] grant_n;
  logic [IDX_W-1:0]   idx_n;
  logic               start_n, busy_n, err_n;
  logic [IDX_W-1:0]   win_idx;
  logic               win_found;

  // First set request scanning upward from the priority pointer, with wrap.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      int unsigned jj;
      logic [IDX_W-1:0] j;
      jj = 32'(ptr) + i;
      if (jj >= NUM_REQ) jj = jj - NUM_REQ;
      j = IDX_W'(jj);
      if (!win_found && req[j]) begin
        win_found = 1'b1;
        win_idx   = j;
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    gap_n   = gap_cnt;
    to_n    = to_cnt;
    grant_n = grant;
    idx_n   = grant_idx;
    err_n   = timeout_err;
    start_n = 1'b0;
    case (state)
      S_IDLE: begin
        if (win_found && fifo_empty) begin
          state_n = S_START;
          grant_n = NUM_REQ'(1) << win_idx;
          idx_n   = win_idx;
          ptr_n   = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + IDX_W'(1);
          start_n = 1'b1;
        end
      end
      S_START: begin
        to_n    = '0;
        state_n = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (msg_done) begin
          state_n = S_GAP;
          gap_n   = GAP_W'(GAP_CYCLES - 1);
          grant_n = '0;
        end else if (tx_busy) begin
          state_n = S_WAIT_DONE;
        end else begin
          to_n = to_cnt + TO_W'(1);
          if (to_n == TO_W'(TIMEOUT_CYCLES - 1)) begin
            err_n   = 1'b1;
            grant_n = '0;
            state_n = S_GAP;
            gap_n   = GAP_W'(GAP_CYCLES - 1);
          end
        end
      end
      S_WAIT_DONE: begin
        if (msg_done) begin
          state_n = S_GAP;
          gap_n   = GAP_W'(GAP_CYCLES - 1);
          grant_n = '0;
        end
      end
      S_GAP: begin
        if (gap_cnt == '0) state_n = S_IDLE;
        else gap_n = gap_cnt - GAP_W'(1);
      end
      default: state_n = S_IDLE;
    endcase
    busy_n = (state_n != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      ptr         <= '0;
      gap_cnt     <= '0;
      to_cnt      <= '0;
      grant       <= '0;
      grant_idx   <= '0;
      start_msg   <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_n;
      ptr         <= ptr_n;
      gap_cnt     <= gap_n;
      to_cnt      <= to_n;
      grant       <= grant_n;
      grant_idx   <= idx_n;
      start_msg   <= start_n;
      busy        <= busy_n;
      timeout_err <= err_n;
    end
  end

endmodule

// File: tb/tb_msg_tx_arbiter.sv
// Directed bench for msg_tx_arbiter: a vector table for the main flows plus
// hand-written sequences for timeout, reset-in-flight and request changes mid-message.
module tb_msg_tx_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned GAP  = 16;
  localparam int unsigned TO   = 1024;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NREQ-1:0] req = '0;
  logic            fifo_empty = 1'b0;
  logic            tx_busy = 1'b0;
  logic            msg_done = 1'b0;
  logic            start_msg;
  logic [NREQ-1:0] grant;
  logic [1:0]      grant_idx;
  logic            busy;
  logic            timeout_err;

  int n_vec  = 0;
  int n_fail = 0;

  msg_tx_arbiter #(
    .NUM_REQ(NREQ), .IDX_W(2), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .fifo_empty(fifo_empty), .tx_busy(tx_busy),
    .msg_done(msg_done), .start_msg(start_msg), .grant(grant), .grant_idx(grant_idx),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       r;
    logic [3:0] rq;
    logic       fe, txb, dn;
    int         rep;
    logic       es;
    logic [3:0] eg;
    logic [1:0] ei;
    logic       eb, ee;
    string      tag;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(logic r, logic [3:0] rq, logic fe, logic txb, logic dn, int rep,
                              logic es, logic [3:0] eg, logic [1:0] ei, logic eb, logic ee,
                              string tag);
    vec_t v;
    v.r = r; v.rq = rq; v.fe = fe; v.txb = txb; v.dn = dn; v.rep = rep;
    v.es = es; v.eg = eg; v.ei = ei; v.eb = eb; v.ee = ee; v.tag = tag;
    tbl.push_back(v);
  endfunction

  // Rows after a START: wait-busy, busy, done, remaining gap, back to idle.
  function automatic void add_tail(logic [3:0] rq, logic [3:0] g, logic [1:0] ei, string tag);
    add(1'b0, rq, 1'b1, 1'b0, 1'b0, 1,   1'b0, g,    ei, 1'b1, 1'b0, {tag, "_wbusy"});
    add(1'b0, rq, 1'b1, 1'b1, 1'b0, 2,   1'b0, g,    ei, 1'b1, 1'b0, {tag, "_wdone"});
    add(1'b0, rq, 1'b1, 1'b0, 1'b1, 1,   1'b0, 4'b0, ei, 1'b1, 1'b0, {tag, "_done"});
    add(1'b0, rq, 1'b1, 1'b0, 1'b0, 15,  1'b0, 4'b0, ei, 1'b1, 1'b0, {tag, "_gap"});
    add(1'b0, rq, 1'b1, 1'b0, 1'b0, 1,   1'b0, 4'b0, ei, 1'b0, 1'b0, {tag, "_idle"});
  endfunction

  task automatic step(input logic r, input logic [3:0] rq, input logic fe, input logic txb,
                      input logic dn, input logic es, input logic [3:0] eg, input logic [1:0] ei,
                      input logic eb, input logic ee, input string tag);
    rst = r; req = rq; fifo_empty = fe; tx_busy = txb; msg_done = dn;
    @(posedge clk);
    #1;
    n_vec++;
    if ({start_msg, grant, grant_idx, busy, timeout_err} !== {es, eg, ei, eb, ee}) begin
      n_fail++;
      $display("FAIL %s @%0t: got start=%b grant=%b idx=%0d busy=%b err=%b, want start=%b grant=%b idx=%0d busy=%b err=%b",
               tag, $time, start_msg, grant, grant_idx, busy, timeout_err, es, eg, ei, eb, ee);
    end
  endtask

  initial begin
    // Basic single message from requester 1.
    add(1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 2, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, "t1_reset");
    add(1'b0, 4'b0010, 1'b1, 1'b0, 1'b0, 1, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b0, "t1_start");
    add_tail(4'b0000, 4'b0010, 2'd1, "t1");
    // Round robin with all requesters held.
    add(1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, "t2_reset");
    for (int k = 0; k < 5; k++) begin
      logic [3:0] g;
      logic [1:0] ix;
      ix = 2'(k % 4);
      g  = 4'(1) << ix;
      add(1'b0, 4'b1111, 1'b1, 1'b0, 1'b0, 1, 1'b1, g, ix, 1'b1, 1'b0, "t2_start");
      add_tail(4'b1111, g, ix, "t2");
    end
    // Request blocked while the FIFO is not empty.
    add(1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1,  1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, "t3_reset");
    add(1'b0, 4'b0100, 1'b0, 1'b0, 1'b0, 20, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, "t3_fifo_busy");
    add(1'b0, 4'b0100, 1'b1, 1'b0, 1'b0, 1,  1'b1, 4'b0100, 2'd2, 1'b1, 1'b0, "t3_start");
    add_tail(4'b0000, 4'b0100, 2'd2, "t3");

    foreach (tbl[i]) begin
      for (int n = 0; n < tbl[i].rep; n++)
        step(tbl[i].r, tbl[i].rq, tbl[i].fe, tbl[i].txb, tbl[i].dn,
             tbl[i].es, tbl[i].eg, tbl[i].ei, tbl[i].eb, tbl[i].ee, tbl[i].tag);
    end

    // Timeout: tx_busy never rises; requester 2 waits throughout.
    step(1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, "t4_reset");
    step(1'b0, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0, "t4_start");
    for (int n = 0; n < int'(TO) - 1; n++)
      step(1'b0, 4'b0100, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0, "t4_waiting");
    step(1'b0, 4'b0100, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b1, 1'b1, "t4_timeout");
    for (int n = 0; n < 15; n++)
      step(1'b0, 4'b0100, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b1, 1'b1, "t4_gap");
    step(1'b0, 4'b0100, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b1, "t4_idle");
    step(1'b0, 4'b0100, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b1, "t4_next_start");
    step(1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b1, "t4_next_wbusy");
    // msg_done together with tx_busy while still waiting for busy: straight to gap.
    step(1'b0, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 2'd2, 1'b1, 1'b1, "t4_early_done");
    for (int n = 0; n < 15; n++)
      step(1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd2, 1'b1, 1'b1, "t4_gap2");
    step(1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd2, 1'b0, 1'b1, "t4_idle2");

    // Reset while waiting for msg_done clears everything including the sticky error.
    step(1'b0, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b1, "t6_start");
    step(1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b1, "t6_wbusy");
    step(1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b1, "t6_wdone");
    step(1'b1, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, "t6_reset");
    step(1'b0, 4'b1000, 1'b1, 1'b0, 1'b0, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b0, "t6_regrant");

    // Request dropped mid-message and another raised: no new grant until done plus gap.
    step(1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, "t5_reset");
    step(1'b0, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0, "t5_start");
    step(1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0, "t5_wbusy");
    for (int n = 0; n < 6; n++)
      step(1'b0, 4'b0010, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0, "t5_hold");
    step(1'b0, 4'b0010, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b1, 1'b0, "t5_done");
    for (int n = 0; n < 15; n++)
      step(1'b0, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b1, 1'b0, "t5_gap");
    step(1'b0, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, "t5_idle");
    step(1'b0, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b0, "t5_next_start");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
